fetch: RTL and testbench
========================

Name: fetch

Overview:
- Instruction fetch stage of the cpu32 pipeline. It sits directly upstream of the decode/execute stage.
- Owns the fetch PC and drives the synchronous instruction SRAM, which has one-cycle read latency.
- Tags each returned word with its PC and presents a registered instruction to decode.
- Absorbs decode stalls through a 2-entry skid queue and handles branch redirects by killing younger work.

Parameters:
- RESET_PC, 32'h00000000, first fetch address after reset.
- COUNTER_W, 32, width of each performance counter (used only with FETCH_PERF_EN).

Ports:
- clk  input  1  clock; all state changes on posedge.
- reset  input  1  synchronous, active-low; 0 = in reset.
- i_addr  output  32  instruction SRAM address, word aligned.
- i_re  output  1  SRAM read request; i_data is valid the cycle after i_re=1.
- i_data  input  32  SRAM read data.
- stall  input  1  decode cannot accept; hold the output registers.
- redirect  input  1  taken branch: flush the stage and refetch.
- redirect_pc  input  32  branch target; bits [1:0] ignored and forced to 0.
- out_valid  output  1  out_ir/out_pc hold a live instruction.
- out_ir  output  32  instruction word.
- out_pc  output  32  address of out_ir.
- out_pc_plus_4  output  32  out_pc+4, registered.
- perf_fetched  output  COUNTER_W  instructions delivered.
- perf_redirects  output  COUNTER_W  redirect events.
- perf_stall_cycles  output  COUNTER_W  cycles with stall && out_valid.

Behaviour:
- Reset (reset=0 at posedge), regardless of any operation in progress:
  - fpc<=RESET_PC; out_valid, out_ir, out_pc, out_pc_plus_4 <=0.
  - Skid count, in-flight flag and kill flag <=0.
  - i_re=0 during any cycle with reset=0.
- Issue:
  - i_addr=fpc, combinational from the register.
  - i_re = reset && !redirect && (skid_count + inflight) < 2, where skid_count and inflight are registered state.
  - i_re is never a function of stall; there is no stall-to-SRAM combinational path.
  - On i_re: fpc<=fpc+4, wrapping modulo 2^32; inflight<=1 with req_pc<=fpc. Otherwise inflight<=0.
- Response: in the cycle after an issue, i_data pairs with req_pc.
  - Discarded if the kill flag is set.
- Output load: occurs when !out_valid || !stall.
  - Source is the skid head if skid_count>0, else the live response.
  - out_pc_plus_4 is loaded as source pc+4.
  - If neither source exists: out_valid<=0.
- Skid push: a live response not consumed by the output load is pushed into the skid queue (FIFO, depth 2).
  - The issue rule guarantees no overflow. Push to a full queue is a design error; the bench asserts it never occurs.
  - Push and pop may occur in the same cycle.
- Stall with out_valid=1: out_* hold their values exactly.
- Throughput: with no stall, one instruction per cycle in steady state.
  - First out_valid=1 occurs in the 3rd cycle after reset deassertion; reset release is cycle 0, the RESET_PC issue happens in cycle 1.
- Redirect (cycle N):
  - out_valid<=0, skid_count<=0, fpc<=redirect_pc.
  - Kill flag<=inflight, so the response arriving in N+1 is dropped. No issue in cycle N.
  - N+1: issue redirect_pc. N+3: out_valid=1, out_pc=redirect_pc.
  - Redirect has priority over stall. Redirect during reset is ignored.
- Consecutive redirects: the last one wins; each one kills all work from earlier ones.

Optional Feature:
- Macro: FETCH_PERF_EN.
- Defined: three saturating COUNTER_W counters, cleared by reset.
  - perf_fetched increments on every load into the output registers with a live source.
  - perf_redirects increments on every cycle with redirect=1 and reset=1.
  - perf_stall_cycles increments on every cycle with stall && out_valid.
  - Each counter holds at all-ones.
- Not defined: the ports remain, are tied to 0, and have no flops.

Test Plan:
- Release reset with i_data = address-derived pattern → i_addr 0,4,8,… on consecutive cycles; out_valid first in cycle 3 with out_pc=0, out_pc_plus_4=4; then one instruction per cycle in order.
- Streaming, then stall=1 for 3 cycles → i_re deasserts after skid_count+inflight reaches 2; out_* frozen; on release, PCs 0x0C,0x10,0x14… appear with no gap, loss or duplicate.
- Redirect to 0x100 while out_valid=1, one response in flight and skid non-empty → out_valid=0 next cycle; no old PC ever appears; out_pc=0x100 valid at N+3.
- redirect=1 and stall=1 in the same cycle with redirect_pc=0x203 → treated as redirect to 0x200; out_valid drops.
- reset=0 for one cycle mid-stall with a full skid → all outputs 0 next cycle; refetch starts at RESET_PC (also run with RESET_PC=0x1000).
- With FETCH_PERF_EN: 10 deliveries, 2 redirects, 4 stalled cycles → counters read 10/2/4. Force saturation with COUNTER_W=4 → counters hold at 15.

Source files
------------

// File: rtl/fetch.sv
// cpu32 instruction fetch stage: PC generation, 1-cycle SRAM issue, 2-entry skid queue, redirect flush.
// Optional FETCH_PERF_EN adds saturating delivery/redirect/stall performance counters.
module fetch #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          COUNTER_W = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  output logic [31:0]          i_addr,
  output logic                 i_re,
  input  logic [31:0]          i_data,
  input  logic                 stall,
  input  logic                 redirect,
  input  logic [31:0]          redirect_pc,
  output logic                 out_valid,
  output logic [31:0]          out_ir,
  output logic [31:0]          out_pc,
  output logic [31:0]          out_pc_plus_4,
  output logic [COUNTER_W-1:0] perf_fetched,
  output logic [COUNTER_W-1:0] perf_redirects,
  output logic [COUNTER_W-1:0] perf_stall_cycles
);

  localparam int SKID_DEPTH = 2;

  logic [31:0] fpc_reg, fpc_next;
  logic        inflight_reg;
  logic [31:0] req_pc_reg;
  logic        kill_reg, kill_next;
  logic [1:0]  skid_count_reg, skid_count_next;
  logic [31:0] skid_pc_reg  [SKID_DEPTH];
  logic [31:0] skid_ir_reg  [SKID_DEPTH];
  logic [31:0] skid_pc_next [SKID_DEPTH];
  logic [31:0] skid_ir_next [SKID_DEPTH];
  logic        out_valid_reg, out_valid_next;
  logic [31:0] out_ir_reg, out_ir_next;
  logic [31:0] out_pc_reg, out_pc_next;
  logic [31:0] out_pc_plus_4_reg, out_pc_plus_4_next;

  logic        issue;
  logic        resp_live;
  logic        out_load;
  logic        take_resp;
  logic        skid_pop;
  logic        skid_push;
  logic [1:0]  occupancy;
  logic [1:0]  push_idx;
  logic [31:0] redirect_target;
  logic        unused_redirect_lo;

  // Issue depends only on registered occupancy, never on stall, so no stall-to-SRAM path exists.
  assign occupancy       = skid_count_reg + {1'b0, inflight_reg};
  assign issue           = reset && !redirect && (occupancy < 2'd2);
  assign i_re            = issue;
  assign i_addr          = fpc_reg;
  assign redirect_target = {redirect_pc[31:2], 2'b00};
  assign unused_redirect_lo = ^redirect_pc[1:0];

  assign resp_live = inflight_reg && !kill_reg;
  assign out_load  = !out_valid_reg || !stall;
  assign skid_pop  = !redirect && out_load && (skid_count_reg != 2'd0);
  assign take_resp = !redirect && out_load && (skid_count_reg == 2'd0) && resp_live;
  assign skid_push = !redirect && resp_live && !take_resp;
  assign push_idx  = skid_count_reg - {1'b0, skid_pop};

  always_comb begin
    fpc_next           = fpc_reg;
    kill_next          = 1'b0;
    skid_count_next    = skid_count_reg;
    out_valid_next     = out_valid_reg;
    out_ir_next        = out_ir_reg;
    out_pc_next        = out_pc_reg;
    out_pc_plus_4_next = out_pc_plus_4_reg;

    if (issue) begin
      fpc_next = fpc_reg + 32'd4;
    end

    if (redirect) begin
      fpc_next        = redirect_target;
      kill_next       = inflight_reg;
      skid_count_next = 2'd0;
      out_valid_next  = 1'b0;
    end else begin
      skid_count_next = skid_count_reg - {1'b0, skid_pop} + {1'b0, skid_push};
      if (skid_pop) begin
        out_valid_next     = 1'b1;
        out_ir_next        = skid_ir_reg[0];
        out_pc_next        = skid_pc_reg[0];
        out_pc_plus_4_next = skid_pc_reg[0] + 32'd4;
      end else if (take_resp) begin
        out_valid_next     = 1'b1;
        out_ir_next        = i_data;
        out_pc_next        = req_pc_reg;
        out_pc_plus_4_next = req_pc_reg + 32'd4;
      end else if (out_load) begin
        out_valid_next = 1'b0;
      end
    end
  end

  // Skid queue is a shift FIFO: entry 0 is always the head.
  genvar gi;
  generate
    for (gi = 0; gi < SKID_DEPTH; gi++) begin : g_skid
      logic [31:0] shift_pc;
      logic [31:0] shift_ir;

      if (gi < SKID_DEPTH - 1) begin : g_shift
        assign shift_pc = skid_pc_reg[gi+1];
        assign shift_ir = skid_ir_reg[gi+1];
      end else begin : g_last
        assign shift_pc = skid_pc_reg[gi];
        assign shift_ir = skid_ir_reg[gi];
      end

      always_comb begin
        skid_pc_next[gi] = skid_pc_reg[gi];
        skid_ir_next[gi] = skid_ir_reg[gi];
        if (skid_pop) begin
          skid_pc_next[gi] = shift_pc;
          skid_ir_next[gi] = shift_ir;
        end
        if (skid_push && (push_idx == 2'(gi))) begin
          skid_pc_next[gi] = req_pc_reg;
          skid_ir_next[gi] = i_data;
        end
      end

      always_ff @(posedge clk) begin
        skid_pc_reg[gi] <= skid_pc_next[gi];
        skid_ir_reg[gi] <= skid_ir_next[gi];
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!reset) begin
      fpc_reg           <= RESET_PC;
      inflight_reg      <= 1'b0;
      req_pc_reg        <= 32'd0;
      kill_reg          <= 1'b0;
      skid_count_reg    <= 2'd0;
      out_valid_reg     <= 1'b0;
      out_ir_reg        <= 32'd0;
      out_pc_reg        <= 32'd0;
      out_pc_plus_4_reg <= 32'd0;
    end else begin
      fpc_reg           <= fpc_next;
      inflight_reg      <= issue;
      if (issue) begin
        req_pc_reg <= fpc_reg;
      end
      kill_reg          <= kill_next;
      skid_count_reg    <= skid_count_next;
      out_valid_reg     <= out_valid_next;
      out_ir_reg        <= out_ir_next;
      out_pc_reg        <= out_pc_next;
      out_pc_plus_4_reg <= out_pc_plus_4_next;
    end
  end

  assign out_valid     = out_valid_reg;
  assign out_ir        = out_ir_reg;
  assign out_pc        = out_pc_reg;
  assign out_pc_plus_4 = out_pc_plus_4_reg;

`ifdef FETCH_PERF_EN
  logic [COUNTER_W-1:0] fetched_reg;
  logic [COUNTER_W-1:0] redirects_reg;
  logic [COUNTER_W-1:0] stall_cycles_reg;
  logic                 deliver;

  assign deliver = skid_pop || take_resp;

  // Counters saturate at all-ones instead of wrapping.
  always_ff @(posedge clk) begin
    if (!reset) begin
      fetched_reg      <= '0;
      redirects_reg    <= '0;
      stall_cycles_reg <= '0;
    end else begin
      if (deliver && (fetched_reg != '1)) begin
        fetched_reg <= fetched_reg + COUNTER_W'(1);
      end
      if (redirect && (redirects_reg != '1)) begin
        redirects_reg <= redirects_reg + COUNTER_W'(1);
      end
      if (stall && out_valid_reg && (stall_cycles_reg != '1)) begin
        stall_cycles_reg <= stall_cycles_reg + COUNTER_W'(1);
      end
    end
  end

  assign perf_fetched      = fetched_reg;
  assign perf_redirects    = redirects_reg;
  assign perf_stall_cycles = stall_cycles_reg;
`else
  assign perf_fetched      = '0;
  assign perf_redirects    = '0;
  assign perf_stall_cycles = '0;
`endif

endmodule

// File: tb/tb_fetch.sv
// Bench for fetch: directed vector table, perf-counter sequences, then randomized traffic
// checked against an in-order delivery scoreboard for two instances (RESET_PC 0 and 0x1000).
module tb_fetch;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'd0;

  logic [31:0] i_addr_w [2];
  logic        i_re_w   [2];
  logic [31:0] i_data_w [2];
  logic        ov_w     [2];
  logic [31:0] ir_w     [2];
  logic [31:0] pc_w     [2];
  logic [31:0] pp4_w    [2];
  logic [31:0] pf0, pr0, ps0;
  logic [3:0]  pf1, pr1, ps1;
  logic [31:0] perf_f [2];
  logic [31:0] perf_r [2];
  logic [31:0] perf_s [2];

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  fetch #(.RESET_PC(32'h0000_0000), .COUNTER_W(32)) dut0 (
    .clk(clk), .reset(reset), .i_addr(i_addr_w[0]), .i_re(i_re_w[0]), .i_data(i_data_w[0]),
    .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
    .out_valid(ov_w[0]), .out_ir(ir_w[0]), .out_pc(pc_w[0]), .out_pc_plus_4(pp4_w[0]),
    .perf_fetched(pf0), .perf_redirects(pr0), .perf_stall_cycles(ps0)
  );

  fetch #(.RESET_PC(32'h0000_1000), .COUNTER_W(4)) dut1 (
    .clk(clk), .reset(reset), .i_addr(i_addr_w[1]), .i_re(i_re_w[1]), .i_data(i_data_w[1]),
    .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
    .out_valid(ov_w[1]), .out_ir(ir_w[1]), .out_pc(pc_w[1]), .out_pc_plus_4(pp4_w[1]),
    .perf_fetched(pf1), .perf_redirects(pr1), .perf_stall_cycles(ps1)
  );

  assign perf_f[0] = pf0;
  assign perf_r[0] = pr0;
  assign perf_s[0] = ps0;
  assign perf_f[1] = {28'd0, pf1};
  assign perf_r[1] = {28'd0, pr1};
  assign perf_s[1] = {28'd0, ps1};

  function automatic logic [31:0] pat(input logic [31:0] a);
    return a ^ 32'hC0DE_F00D;
  endfunction

  function automatic logic [31:0] sat_inc(input logic [31:0] v, input int k);
    logic [31:0] mx;
    mx = (k == 0) ? 32'hFFFF_FFFF : 32'h0000_000F;
    return (v == mx) ? v : v + 32'd1;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  // SRAM model: data valid the cycle after a read, junk otherwise.
  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (i_re_w[k]) i_data_w[k] <= pat(i_addr_w[k]);
      else           i_data_w[k] <= $urandom;
    end
  end

  // Scoreboard: pre-edge snapshot at posedge, checks of the resulting state at negedge.
  logic        p_rst, p_stall, p_rdr;
  logic [31:0] p_rpc;
  logic        p_ov   [2];
  logic        p_ire  [2];
  logic [31:0] p_ir   [2];
  logic [31:0] p_pc   [2];
  logic [31:0] p_pp4  [2];
  logic [31:0] p_addr [2];
  logic [31:0] exp_pc [2];
  logic [31:0] m_f [2];
  logic [31:0] m_r [2];
  logic [31:0] m_s [2];
  int          good [2];
  logic [31:0] rst_pc [2];

  initial begin
    rst_pc[0] = 32'h0000_0000;
    rst_pc[1] = 32'h0000_1000;
  end

  always @(posedge clk) begin
    p_rst = reset;
    p_stall = stall;
    p_rdr = redirect;
    p_rpc = redirect_pc;
    for (int k = 0; k < 2; k++) begin
      p_ov[k] = ov_w[k];
      p_ire[k] = i_re_w[k];
      p_ir[k] = ir_w[k];
      p_pc[k] = pc_w[k];
      p_pp4[k] = pp4_w[k];
      p_addr[k] = i_addr_w[k];
    end
    chk("skid_overflow0", 32'(dut0.skid_push && (dut0.skid_count_reg == 2'd2)), 32'd0);
    chk("skid_overflow1", 32'(dut1.skid_push && (dut1.skid_count_reg == 2'd2)), 32'd0);
  end

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (!p_rst) begin
        chk($sformatf("rst_valid%0d", k), 32'(ov_w[k]), 32'd0);
        chk($sformatf("rst_ir%0d", k), ir_w[k], 32'd0);
        chk($sformatf("rst_pc%0d", k), pc_w[k], 32'd0);
        chk($sformatf("rst_pc4_%0d", k), pp4_w[k], 32'd0);
        chk($sformatf("rst_i_re%0d", k), 32'(p_ire[k]), 32'd0);
        chk($sformatf("rst_i_addr%0d", k), i_addr_w[k], rst_pc[k]);
        exp_pc[k] = rst_pc[k];
        good[k] = 0;
        m_f[k] = 32'd0;
        m_r[k] = 32'd0;
        m_s[k] = 32'd0;
      end else begin
        if (p_stall && p_ov[k]) m_s[k] = sat_inc(m_s[k], k);
        if (p_rdr) begin
          chk($sformatf("redir_valid%0d", k), 32'(ov_w[k]), 32'd0);
          chk($sformatf("redir_i_addr%0d", k), i_addr_w[k], {p_rpc[31:2], 2'b00});
          exp_pc[k] = {p_rpc[31:2], 2'b00};
          good[k] = 0;
          m_r[k] = sat_inc(m_r[k], k);
        end else begin
          good[k]++;
          if (p_stall && p_ov[k]) begin
            chk($sformatf("hold_valid%0d", k), 32'(ov_w[k]), 32'd1);
            chk($sformatf("hold_ir%0d", k), ir_w[k], p_ir[k]);
            chk($sformatf("hold_pc%0d", k), pc_w[k], p_pc[k]);
            chk($sformatf("hold_pc4_%0d", k), pp4_w[k], p_pp4[k]);
          end else if (ov_w[k]) begin
            chk($sformatf("deliver_pc%0d", k), pc_w[k], exp_pc[k]);
            chk($sformatf("deliver_ir%0d", k), ir_w[k], pat(exp_pc[k]));
            chk($sformatf("deliver_pc4_%0d", k), pp4_w[k], exp_pc[k] + 32'd4);
            exp_pc[k] = exp_pc[k] + 32'd4;
            m_f[k] = sat_inc(m_f[k], k);
          end
          if (good[k] >= 2) chk($sformatf("liveness%0d", k), 32'(ov_w[k]), 32'd1);
          chk($sformatf("fpc_step%0d", k), i_addr_w[k], p_ire[k] ? p_addr[k] + 32'd4 : p_addr[k]);
        end
      end
      chk($sformatf("align%0d", k), 32'(i_addr_w[k][1:0]), 32'd0);
`ifdef FETCH_PERF_EN
      chk($sformatf("perf_fetched%0d", k), perf_f[k], m_f[k]);
      chk($sformatf("perf_redirects%0d", k), perf_r[k], m_r[k]);
      chk($sformatf("perf_stall%0d", k), perf_s[k], m_s[k]);
`else
      chk($sformatf("perf_fetched%0d", k), perf_f[k], 32'd0);
      chk($sformatf("perf_redirects%0d", k), perf_r[k], 32'd0);
      chk($sformatf("perf_stall%0d", k), perf_s[k], 32'd0);
`endif
    end
  end

  task automatic step(input logic r, input logic s, input logic d, input logic [31:0] pc);
    @(negedge clk);
    reset = r;
    stall = s;
    redirect = d;
    redirect_pc = pc;
  endtask

  typedef struct {
    logic        rst;
    logic        stl;
    logic        rdr;
    logic [31:0] rpc;
    logic        e_ire;
    logic [31:0] e_addr;
    logic        e_ov;
    logic [31:0] e_pc;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(input logic rst, input logic stl, input logic rdr, input logic [31:0] rpc,
                              input logic ire, input logic [31:0] addr, input logic ov, input logic [31:0] pc);
    vec_t v;
    v.rst = rst; v.stl = stl; v.rdr = rdr; v.rpc = rpc;
    v.e_ire = ire; v.e_addr = addr; v.e_ov = ov; v.e_pc = pc;
    return v;
  endfunction

  initial begin
    // Row = inputs for one cycle plus instance-0 state expected during that cycle.
    vq.push_back(mk(0, 0, 0, 32'h0,   0, 32'h000, 0, 32'h0));
    vq.push_back(mk(1, 0, 0, 32'h0,   1, 32'h000, 0, 32'h0));
    vq.push_back(mk(1, 0, 0, 32'h0,   1, 32'h004, 0, 32'h0));
    vq.push_back(mk(1, 0, 0, 32'h0,   1, 32'h008, 1, 32'h000));
    vq.push_back(mk(1, 0, 0, 32'h0,   1, 32'h00C, 1, 32'h004));
    vq.push_back(mk(1, 1, 0, 32'h0,   1, 32'h010, 1, 32'h008));
    vq.push_back(mk(1, 1, 0, 32'h0,   0, 32'h014, 1, 32'h008));
    vq.push_back(mk(1, 1, 0, 32'h0,   0, 32'h014, 1, 32'h008));
    vq.push_back(mk(1, 0, 0, 32'h0,   0, 32'h014, 1, 32'h008));
    vq.push_back(mk(1, 0, 0, 32'h0,   1, 32'h014, 1, 32'h00C));
    vq.push_back(mk(1, 0, 0, 32'h0,   1, 32'h018, 1, 32'h010));
    vq.push_back(mk(1, 1, 0, 32'h0,   1, 32'h01C, 1, 32'h014));
    vq.push_back(mk(1, 0, 1, 32'h100, 0, 32'h020, 1, 32'h014));
    vq.push_back(mk(1, 0, 0, 32'h0,   1, 32'h100, 0, 32'h0));
    vq.push_back(mk(1, 0, 0, 32'h0,   1, 32'h104, 0, 32'h0));
    vq.push_back(mk(1, 0, 0, 32'h0,   1, 32'h108, 1, 32'h100));
    vq.push_back(mk(1, 1, 1, 32'h203, 0, 32'h10C, 1, 32'h104));
    vq.push_back(mk(1, 1, 0, 32'h0,   1, 32'h200, 0, 32'h0));
    vq.push_back(mk(1, 1, 0, 32'h0,   1, 32'h204, 0, 32'h0));
    vq.push_back(mk(1, 1, 0, 32'h0,   1, 32'h208, 1, 32'h200));
    vq.push_back(mk(1, 1, 0, 32'h0,   0, 32'h20C, 1, 32'h200));
    vq.push_back(mk(0, 1, 0, 32'h0,   0, 32'h20C, 1, 32'h200));
    vq.push_back(mk(1, 1, 0, 32'h0,   1, 32'h000, 0, 32'h0));
    vq.push_back(mk(1, 1, 0, 32'h0,   1, 32'h004, 0, 32'h0));
    vq.push_back(mk(1, 0, 0, 32'h0,   1, 32'h008, 1, 32'h000));
    vq.push_back(mk(1, 0, 0, 32'h0,   1, 32'h00C, 1, 32'h004));

    step(0, 0, 0, 32'h0);
    step(0, 0, 0, 32'h0);

    foreach (vq[i]) begin
      step(vq[i].rst, vq[i].stl, vq[i].rdr, vq[i].rpc);
      #1;
      chk($sformatf("tbl%0d_i_re", i), 32'(i_re_w[0]), 32'(vq[i].e_ire));
      chk($sformatf("tbl%0d_i_addr", i), i_addr_w[0], vq[i].e_addr);
      chk($sformatf("tbl%0d_valid", i), 32'(ov_w[0]), 32'(vq[i].e_ov));
      if (vq[i].e_ov) chk($sformatf("tbl%0d_pc", i), pc_w[0], vq[i].e_pc);
    end

    // Perf sequence: 10 deliveries, 4 stalled valid cycles, 2 redirects.
    step(0, 0, 0, 32'h0);
    for (int c = 1; c <= 17; c++) begin
      step(1, (c >= 7 && c <= 10), (c >= 16), 32'h0000_0040);
    end
    step(1, 0, 0, 32'h0);
    #1;
`ifdef FETCH_PERF_EN
    chk("perf_seq_fetched0", pf0, 32'd10);
    chk("perf_seq_redirects0", pr0, 32'd2);
    chk("perf_seq_stall0", ps0, 32'd4);
    chk("perf_seq_fetched1", 32'(pf1), 32'd10);
    chk("perf_seq_redirects1", 32'(pr1), 32'd2);
    chk("perf_seq_stall1", 32'(ps1), 32'd4);
`else
    chk("perf_seq_fetched0", pf0, 32'd0);
    chk("perf_seq_redirects0", pr0, 32'd0);
    chk("perf_seq_stall0", ps0, 32'd0);
`endif

    // Saturation of the 4-bit counters.
    for (int c = 0; c < 20; c++) step(1, 0, 0, 32'h0);
    for (int c = 0; c < 20; c++) step(1, 1, 0, 32'h0);
    for (int c = 0; c < 20; c++) step(1, 0, 1, $urandom);
    step(1, 0, 0, 32'h0);
    #1;
`ifdef FETCH_PERF_EN
    chk("sat_fetched1", 32'(pf1), 32'd15);
    chk("sat_redirects1", 32'(pr1), 32'd15);
    chk("sat_stall1", 32'(ps1), 32'd15);
    chk("nosat_redirects0", pr0, 32'd22);
`else
    chk("sat_fetched1", 32'(pf1), 32'd0);
    chk("sat_redirects1", 32'(pr1), 32'd0);
    chk("sat_stall1", 32'(ps1), 32'd0);
`endif

    // Randomized traffic with alternating light/heavy stall phases.
    step(0, 0, 0, 32'h0);
    for (int c = 0; c < 3000; c++) begin
      int stall_pct;
      stall_pct = ((c / 64) % 2 == 1) ? 80 : 25;
      step(($urandom_range(99) != 0),
           ($urandom_range(99) < stall_pct),
           ($urandom_range(99) < 7),
           $urandom);
    end
    step(1, 0, 0, 32'h0);
    step(1, 0, 0, 32'h0);
    step(1, 0, 0, 32'h0);
    @(negedge clk);
    #1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not reach the end, required completion");
    $fatal(1, "watchdog");
  end

endmodule
